// File: rtl/display_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_scanner_pkg
//  Purpose  : Shared constants for the guess-entry display path: active-low
//             7-segment patterns, position count and buffer width.
//  Revision : 1.0  initial release
// ============================================================================
package display_scanner_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [6:0] SEG_DASH    = 7'h3F;
    localparam logic [6:0] SEG_DIGIT_0 = 7'h40;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h79;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h24;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h30;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h19;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h12;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h02;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h78;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h00;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h10;

    localparam int          NUM_POS    = 5;
    localparam int          BUF_W      = 17;
    localparam logic [4:0]  ANODE_OFF  = 5'h1F;

    // Buffer contents after the entry block comes out of reset: "1" on the
    // leading position, zeros on the digit positions.
    localparam logic [BUF_W-1:0] SHADOW_RESET = 17'h10000;

    // Active-low one-hot anode enable for a display position.
    function automatic logic [4:0] anode_for(input logic [2:0] pos);
        logic [4:0] onehot;
        onehot = 5'b00001 << pos;
        return ~onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_scanner_seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational BCD nibble to active-low 7-segment pattern.
//             Non-decimal nibbles show a dash so corrupt data is visible.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import display_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Lookup of the standard digit shapes.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_DIGIT_0;
            4'd1:    seg = SEG_DIGIT_1;
            4'd2:    seg = SEG_DIGIT_2;
            4'd3:    seg = SEG_DIGIT_3;
            4'd4:    seg = SEG_DIGIT_4;
            4'd5:    seg = SEG_DIGIT_5;
            4'd6:    seg = SEG_DIGIT_6;
            4'd7:    seg = SEG_DIGIT_7;
            4'd8:    seg = SEG_DIGIT_8;
            4'd9:    seg = SEG_DIGIT_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : display_scanner
//  Purpose  : Drives a 5-position multiplexed common-anode 7-segment display
//             from the guess-entry buffer. The buffer and cursor are sampled
//             once per frame; the cursor position blinks when enabled.
//  Revision : 1.0  initial release
// ============================================================================
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BUF_W-1:0] data_buffer,
    input  logic [2:0]       i,
    input  logic             blink_en,
    output logic [6:0]       seg,
    output logic [4:0]       an,
    output logic             dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(BLINK_DIV + 1);

    logic [PW-1:0]    prescaler;
    logic [2:0]       slot;
    logic             blink_phase;
    logic [FW-1:0]    frame_cnt;
    logic [BUF_W-1:0] shadow;
    logic [2:0]       cur_q;

    logic             tick;
    logic             frame_end;
    logic [3:0]       nibble;
    logic [6:0]       digit_seg;
    logic [6:0]       slot_seg;
    logic             blank_now;
    logic             cursor_valid;

    assign tick         = (prescaler == PW'(SCAN_DIV - 1));
    assign frame_end    = tick && (slot == 3'd4);
    assign cursor_valid = (cur_q <= 3'd4);
    assign blank_now    = blink_en && cursor_valid && (slot == cur_q) && blink_phase;

    // Select the digit nibble for the position being scanned.
    always_comb begin
        nibble = 4'd0;
        case (slot)
            3'd0:    nibble = shadow[3:0];
            3'd1:    nibble = shadow[7:4];
            3'd2:    nibble = shadow[11:8];
            3'd3:    nibble = shadow[15:12];
            default: nibble = 4'd0;
        endcase
    end

    seg7_decode u_decode (
        .bcd (nibble),
        .seg (digit_seg)
    );

    // Leading position only ever shows a "1" or nothing.
    always_comb begin
        slot_seg = digit_seg;
        if (slot == 3'd4) begin
            slot_seg = shadow[16] ? SEG_DIGIT_1 : SEG_BLANK;
        end
    end

    // Scan prescaler, position counter, frame sampling and blink timebase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler   <= '0;
            slot        <= 3'd0;
            blink_phase <= 1'b0;
            frame_cnt   <= '0;
            shadow      <= SHADOW_RESET;
            cur_q       <= 3'd0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) begin
                slot <= (slot == 3'd4) ? 3'd0 : slot + 3'd1;
            end
            // Whole-frame snapshot so a buffer update never tears the display.
            if (frame_end) begin
                shadow <= data_buffer;
                cur_q  <= i;
                if (frame_cnt == FW'(BLINK_DIV - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

    // Registered display drive; one blank cycle on every position change
    // stops the outgoing digit ghosting onto the incoming anode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_BLANK;
            an  <= ANODE_OFF;
            dp  <= 1'b1;
        end else if (tick) begin
            seg <= SEG_BLANK;
            an  <= ANODE_OFF;
            dp  <= 1'b1;
        end else begin
            seg <= blank_now ? SEG_BLANK : slot_seg;
            an  <= anode_for(slot);
            dp  <= !((slot == 3'd0) && !cursor_valid);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_scanner
//  Purpose  : Self-checking bench for display_scanner with SCAN_DIV=4,
//             BLINK_DIV=2 (4 cycles per position, 20 cycles per frame).
//  Revision : 1.0  initial release
// ============================================================================
module tb_display_scanner;

    logic        clk;
    logic        reset;
    logic [16:0] data_buffer;
    logic [2:0]  i;
    logic        blink_en;
    logic [6:0]  seg;
    logic [4:0]  an;
    logic        dp;

    int errors = 0;
    int checks = 0;
    int frame  = 0;

    display_scanner #(
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_buffer (data_buffer),
        .i           (i),
        .blink_en    (blink_en),
        .seg         (seg),
        .an          (an),
        .dp          (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0]      data;
        logic [2:0]       cur;
        logic             be;
        logic [4:0][6:0]  segs;   // expected pattern per position, unblanked
        logic             dp0;    // 1 = decimal point lit on position 0
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (frame %0d, t=%0t)", nm, act, exp, frame, $time);
        end
    endtask

    // Sample just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic anode_exp(input int pos, output logic [4:0] a);
        a = 5'h1F;
        a[pos] = 1'b0;
    endtask

    // Check one full frame; call right after a frame-end edge has been sampled.
    task automatic check_frame(input logic [4:0][6:0] segs, input logic dp0, input string nm);
        logic [4:0] a;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k % 4 == 0) begin
                chk({nm, " gap an"},  {2'b00, an}, 7'h1F);
                chk({nm, " gap seg"}, seg, 7'h7F);
            end else begin
                anode_exp((k - 1) / 4, a);
                chk({nm, " an"},  {2'b00, an}, {2'b00, a});
                chk({nm, " seg"}, seg, segs[(k - 1) / 4]);
                chk({nm, " dp"},  {6'd0, dp}, {6'd0, !(((k - 1) / 4 == 0) && dp0)});
            end
        end
        frame++;
    endtask

    task automatic skip_frame();
        repeat (20) @(posedge clk);
        #1;
        frame++;
    endtask

    function automatic logic blink_phase_of(input int f);
        return ((f >> 1) & 1) != 0;
    endfunction

    initial begin
        logic [4:0][6:0] exp;
        logic [4:0]      a;

        vecs[0] = '{17'h11234, 3'd7, 1'b0, {7'h79, 7'h79, 7'h24, 7'h30, 7'h19}, 1'b1};
        vecs[1] = '{17'h0ABCD, 3'd7, 1'b0, {7'h7F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        vecs[2] = '{17'h05678, 3'd2, 1'b1, {7'h7F, 7'h12, 7'h02, 7'h78, 7'h00}, 1'b0};
        vecs[3] = '{17'h05678, 3'd2, 1'b1, {7'h7F, 7'h12, 7'h02, 7'h78, 7'h00}, 1'b0};
        vecs[4] = '{17'h19090, 3'd4, 1'b1, {7'h79, 7'h10, 7'h40, 7'h10, 7'h40}, 1'b0};
        vecs[5] = '{17'h10000, 3'd0, 1'b0, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
        vecs[6] = '{17'h1EF12, 3'd5, 1'b1, {7'h79, 7'h3F, 7'h3F, 7'h79, 7'h24}, 1'b1};

        // Reset state.
        reset = 1'b0;
        data_buffer = 17'h00000;
        i = 3'd0;
        blink_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset seg", seg, 7'h7F);
        chk("reset an",  {2'b00, an}, 7'h1F);
        chk("reset dp",  {6'd0, dp}, 7'd1);
        @(negedge clk);
        reset = 1'b1;

        // First frame shows the reset shadow.
        frame = 0;
        check_frame({7'h79, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, "rst frame");

        // Table of static patterns: load, let one frame end sample it, check.
        for (int v = 0; v < 7; v++) begin
            data_buffer = vecs[v].data;
            i           = vecs[v].cur;
            blink_en    = vecs[v].be;
            skip_frame();
            exp = vecs[v].segs;
            if (vecs[v].be && vecs[v].cur <= 3'd4 && blink_phase_of(frame))
                exp[vecs[v].cur] = 7'h7F;
            check_frame(exp, vecs[v].dp0, $sformatf("vec%0d", v));
        end

        // Blink disable takes effect immediately, mid-frame.
        data_buffer = 17'h05678;
        i = 3'd2;
        blink_en = 1'b1;
        skip_frame();
        skip_frame();
        skip_frame();                         // now in frame 18, blink phase on
        repeat (2) step();                    // slot 0 shown
        chk("blink on seg0", seg, 7'h00);
        repeat (6) step();                    // edge 8: gap before slot 2
        blink_en = 1'b0;
        step();                               // edge 9: slot 2 visible
        chk("blink off seg2", seg, 7'h02);
        blink_en = 1'b1;
        step();                               // edge 10: blanked again
        chk("blink on seg2", seg, 7'h7F);
        blink_en = 1'b0;

        // Mid-frame buffer change does not tear the current frame.
        data_buffer = 17'h09999;
        step(); step();                       // edges 11, 12
        chk("nt gap seg", seg, 7'h7F);
        step();                               // edge 13: slot 3
        chk("nt seg3", seg, 7'h12);
        repeat (4) step();                    // edge 17: slot 4
        chk("nt seg4", seg, 7'h7F);
        repeat (3) step();                    // edge 20: frame end
        frame++;
        check_frame({7'h7F, 7'h10, 7'h10, 7'h10, 7'h10}, 1'b0, "new data");

        // Asynchronous reset during slot 3, then restart from zero.
        data_buffer = 17'h11234;
        i = 3'd7;
        repeat (13) step();                   // slot 3 visible
        anode_exp(3, a);
        chk("pre-rst an", {2'b00, an}, {2'b00, a});
        #2;
        reset = 1'b0;
        #1;
        chk("async rst an",  {2'b00, an}, 7'h1F);
        chk("async rst seg", seg, 7'h7F);
        chk("async rst dp",  {6'd0, dp}, 7'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        frame = 0;
        check_frame({7'h79, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, "post-rst");
        check_frame({7'h79, 7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, "post-rst data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
